// File: rtl/axi4_stream_pkg.sv
// Shared AXI4-stream definitions: packed beat record and the last-beat byte-enable helper.
package axi4_stream_pkg;

    localparam int unsigned AXIS_MAX_TDATA_W = 1024;
    localparam int unsigned AXIS_MAX_BYTES   = AXIS_MAX_TDATA_W / 8;
    localparam int unsigned AXIS_MAX_TUSER_W = 32;
    localparam int unsigned AXIS_MAX_TDEST_W = 32;
    localparam int unsigned AXIS_MAX_TID_W   = 32;

    typedef struct packed {
        logic [AXIS_MAX_TDATA_W-1:0] tdata;
        logic [AXIS_MAX_BYTES-1:0]   tstrb;
        logic [AXIS_MAX_BYTES-1:0]   tkeep;
        logic                        tlast;
        logic [AXIS_MAX_TUSER_W-1:0] tuser;
        logic [AXIS_MAX_TDEST_W-1:0] tdest;
        logic [AXIS_MAX_TID_W-1:0]   tid;
    } axi4_stream_word_t;

    // A zero remainder means the final word is completely filled.
    function automatic logic [AXIS_MAX_BYTES-1:0] axis_keep_from_rem(
        input int unsigned rem,
        input int unsigned nbytes
    );
        logic [AXIS_MAX_BYTES-1:0] mask;
        int unsigned               nset;
        nset = (rem == 0) ? nbytes : rem;
        mask = '0;
        for (int unsigned i = 0; i < AXIS_MAX_BYTES; i++) begin
            if (i < nset) mask[i] = 1'b1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// AXI4-stream bundle with master and slave views.
interface axi4_stream_if #(
    parameter int unsigned TDATA_WIDTH = 32,
    parameter int unsigned TUSER_WIDTH = 1,
    parameter int unsigned TDEST_WIDTH = 1,
    parameter int unsigned TID_WIDTH   = 1
) ();

    localparam int unsigned TKEEP_WIDTH = TDATA_WIDTH / 8;

    logic                   tvalid;
    logic                   tready;
    logic [TDATA_WIDTH-1:0] tdata;
    logic [TKEEP_WIDTH-1:0] tstrb;
    logic [TKEEP_WIDTH-1:0] tkeep;
    logic                   tlast;
    logic [TUSER_WIDTH-1:0] tuser;
    logic [TDEST_WIDTH-1:0] tdest;
    logic [TID_WIDTH-1:0]   tid;

    modport master (
        output tvalid, tdata, tstrb, tkeep, tlast, tuser, tdest, tid,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tstrb, tkeep, tlast, tuser, tdest, tid,
        output tready
    );

endinterface

// File: rtl/axi4_stream_pkt_tx.sv
// Packet transmitter: turns a sized command plus a show-ahead word source into one AXI4-stream packet.
module axi4_stream_pkt_tx
    import axi4_stream_pkg::*;
#(
    parameter int unsigned TDATA_WIDTH    = 32,
    parameter int unsigned TUSER_WIDTH    = 1,
    parameter int unsigned TDEST_WIDTH    = 1,
    parameter int unsigned TID_WIDTH      = 1,
    parameter int unsigned PKT_SIZE_WIDTH = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic [PKT_SIZE_WIDTH:0]   cmd_size_i,
    input  logic [TUSER_WIDTH-1:0]    cmd_tuser_i,
    input  logic [TDEST_WIDTH-1:0]    cmd_tdest_i,
    input  logic [TID_WIDTH-1:0]      cmd_tid_i,
    input  logic [TDATA_WIDTH-1:0]    data_i,
    input  logic                      data_empty_i,
    output logic                      data_rd_o,
    output logic                      busy_o,
    output logic                      pkt_sent_o,
    output logic                      size_err_o,
    axi4_stream_if.master             pkt_o
);

    localparam int unsigned BYTES = TDATA_WIDTH / 8;
    localparam int unsigned CW    = PKT_SIZE_WIDTH + 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    localparam logic [CW:0]   BYTES_X  = (CW + 1)'(BYTES);
    localparam logic [CW-1:0] ONE_WORD = CW'(1);

    logic [0:0]             state_q;
    logic [CW-1:0]          words_q;
    logic [BYTES-1:0]       last_keep_q;
    logic [TUSER_WIDTH-1:0] cmd_tuser_q;
    logic [TDEST_WIDTH-1:0] cmd_tdest_q;
    logic [TID_WIDTH-1:0]   cmd_tid_q;

    logic                   tvalid_q;
    logic [TDATA_WIDTH-1:0] tdata_q;
    logic [BYTES-1:0]       tkeep_q;
    logic                   tlast_q;
    logic [TUSER_WIDTH-1:0] tuser_q;
    logic [TDEST_WIDTH-1:0] tdest_q;
    logic [TID_WIDTH-1:0]   tid_q;
    logic                   pkt_sent_q;
    logic                   size_err_q;

    logic             cmd_hs;
    logic             size_zero;
    logic [CW:0]      size_x;
    logic [CW-1:0]    words_calc;
    logic [CW:0]      rem_calc;
    logic [BYTES-1:0] keep_calc;
    logic             load;
    logic             last_word;

    always_comb begin
        cmd_hs     = cmd_valid_i && (state_q == ST_IDLE);
        size_zero  = (cmd_size_i == '0);
        size_x     = {1'b0, cmd_size_i};
        words_calc = CW'((size_x + BYTES_X - 1'b1) / BYTES_X);
        rem_calc   = size_x % BYTES_X;
        keep_calc  = BYTES'(axis_keep_from_rem(32'(rem_calc), BYTES));
        // Gating with reset stops any pop from the source while reset is asserted.
        load       = rst_n_i && (state_q == ST_SEND) && !data_empty_i
                     && (!tvalid_q || pkt_o.tready);
        last_word  = (words_q == ONE_WORD);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            words_q    <= '0;
            tvalid_q   <= 1'b0;
            pkt_sent_q <= 1'b0;
            size_err_q <= 1'b0;
        end else begin
            size_err_q <= cmd_hs && size_zero;
            pkt_sent_q <= tvalid_q && pkt_o.tready && tlast_q;

            if (cmd_hs && !size_zero) begin
                state_q <= ST_SEND;
                words_q <= words_calc;
            end else if (load) begin
                words_q <= words_q - 1'b1;
                if (last_word) state_q <= ST_IDLE;
            end

            if (load) begin
                tvalid_q <= 1'b1;
            end else if (pkt_o.tready) begin
                tvalid_q <= 1'b0;
            end
        end
    end

    // Datapath carries no reset; contents only matter while tvalid is high.
    always_ff @(posedge clk_i) begin
        if (cmd_hs) begin
            last_keep_q <= keep_calc;
            cmd_tuser_q <= cmd_tuser_i;
            cmd_tdest_q <= cmd_tdest_i;
            cmd_tid_q   <= cmd_tid_i;
        end
        if (load) begin
            tdata_q <= data_i;
            tkeep_q <= last_word ? last_keep_q : '1;
            tlast_q <= last_word;
            tuser_q <= cmd_tuser_q;
            tdest_q <= cmd_tdest_q;
            tid_q   <= cmd_tid_q;
        end
    end

    assign cmd_ready_o  = (state_q == ST_IDLE);
    assign data_rd_o    = load;
    assign busy_o       = (state_q == ST_SEND) || tvalid_q;
    assign pkt_sent_o   = pkt_sent_q;
    assign size_err_o   = size_err_q;

    assign pkt_o.tvalid = tvalid_q;
    assign pkt_o.tdata  = tdata_q;
    assign pkt_o.tkeep  = tkeep_q;
    assign pkt_o.tstrb  = tkeep_q;
    assign pkt_o.tlast  = tlast_q;
    assign pkt_o.tuser  = tuser_q;
    assign pkt_o.tdest  = tdest_q;
    assign pkt_o.tid    = tid_q;

endmodule

// File: tb/tb_axi4_stream_pkt_tx.sv
// Self-checking bench for axi4_stream_pkt_tx: directed table, corner sequences and randomized scoreboard run.
module tb_axi4_stream_pkt_tx;

    localparam int PW = 16;

    logic        clk = 1'b0;
    logic        rst_n_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [PW:0] cmd_size_i;
    logic        cmd_tuser_i, cmd_tdest_i, cmd_tid_i;
    logic [31:0] data_i;
    logic        data_empty_i, data_rd_o, busy_o, pkt_sent_o, size_err_o;

    always #5 clk = ~clk;

    axi4_stream_if #(.TDATA_WIDTH(32), .TUSER_WIDTH(1), .TDEST_WIDTH(1), .TID_WIDTH(1)) pkt_if ();

    axi4_stream_pkt_tx #(
        .TDATA_WIDTH(32), .TUSER_WIDTH(1), .TDEST_WIDTH(1), .TID_WIDTH(1), .PKT_SIZE_WIDTH(PW)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_size_i(cmd_size_i),
        .cmd_tuser_i(cmd_tuser_i), .cmd_tdest_i(cmd_tdest_i), .cmd_tid_i(cmd_tid_i),
        .data_i(data_i), .data_empty_i(data_empty_i), .data_rd_o(data_rd_o),
        .busy_o(busy_o), .pkt_sent_o(pkt_sent_o), .size_err_o(size_err_o),
        .pkt_o(pkt_if)
    );

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic        user, dest, id;
    } beat_t;

    typedef struct {
        int         size;
        int         mode;       // 0 ready always, 1 toggling, 2 random
        int         exp_beats;
        logic [3:0] exp_last_keep;
        int         exp_err;
    } vec_t;

    beat_t       exp_q[$];
    logic [31:0] src_q[$];
    logic [31:0] pend_q[$];
    vec_t        tbl[7];

    int checks = 0, failures = 0;
    int rd_cnt = 0, sent_cnt = 0, err_cnt = 0, beat_cnt = 0, cyc = 0;
    logic [3:0] last_keep_seen;
    int   ready_mode = 0;
    logic gate_rand = 1'b0, gate_hold = 1'b0, rnd_ready = 1'b1, rnd_gate = 1'b0;

    logic        mon_armed = 1'b0, exp_sent = 1'b0, stall_pend = 1'b0;
    logic [44:0] hold_vec;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic refresh();
        case (ready_mode)
            0:       pkt_if.tready = 1'b1;
            1:       pkt_if.tready = cyc[0];
            default: pkt_if.tready = rnd_ready;
        endcase
        data_empty_i = gate_hold || (gate_rand && rnd_gate) || (src_q.size() == 0);
        data_i       = (src_q.size() > 0) ? src_q[0] : 32'hDEAD_BEEF;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        rnd_ready = ($urandom_range(0, 9) < 7);
        rnd_gate  = ($urandom_range(0, 3) == 0);
        refresh();
    endtask

    task automatic clear_counts();
        rd_cnt = 0; sent_cnt = 0; err_cnt = 0; beat_cnt = 0; last_keep_seen = 4'h0;
    endtask

    // Expected beats follow directly from the byte count: beat i carries min(4, size-4i) bytes.
    task automatic issue(input int size, input logic u, input logic d, input logic id);
        int    n;
        int    left;
        int    nb;
        beat_t b;
        n = (size + 3) / 4;
        for (int i = 0; i < n; i++) begin
            left   = size - 4 * i;
            nb     = (left > 4) ? 4 : left;
            b.data = $urandom;
            b.keep = 4'((1 << nb) - 1);
            b.last = (i == n - 1);
            b.user = u; b.dest = d; b.id = id;
            exp_q.push_back(b);
            pend_q.push_back(b.data);
        end
    endtask

    task automatic push_src(input int k);
        for (int i = 0; i < k && pend_q.size() > 0; i++) src_q.push_back(pend_q.pop_front());
        refresh();
    endtask

    task automatic send_cmd(input int size, input logic u, input logic d, input logic id);
        logic hs;
        logic ok;
        cmd_valid_i = 1'b1; cmd_size_i = (PW + 1)'(size);
        cmd_tuser_i = u; cmd_tdest_i = d; cmd_tid_i = id;
        refresh();
        ok = 1'b0;
        for (int n = 0; n < 400; n++) begin
            hs = cmd_ready_o;
            tick();
            if (hs) begin ok = 1'b1; break; end
        end
        cmd_valid_i = 1'b0;
        refresh();
        if (!ok) begin
            checks++; failures++;
            $display("FAIL cmd_accept_timeout actual=not_accepted required=accepted");
        end
    endtask

    task automatic packet(input int size);
        logic u, d, id;
        u = 1'($urandom); d = 1'($urandom); id = 1'($urandom);
        issue(size, u, d, id);
        push_src(pend_q.size());
        send_cmd(size, u, d, id);
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            if (!busy_o && exp_q.size() == 0) begin ok = 1'b1; break; end
            tick();
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL drain_timeout actual=busy_or_beats_pending(%0d) required=idle", exp_q.size());
        end
        tick(); tick();
    endtask

    // Monitor: scoreboard on every handshake, AXI hold rule, pkt_sent timing, pop tracking.
    always @(posedge clk) begin
        beat_t e;
        logic [44:0] cur;
        cur = {pkt_if.tvalid, pkt_if.tdata, pkt_if.tkeep, pkt_if.tstrb, pkt_if.tlast,
               pkt_if.tuser, pkt_if.tdest, pkt_if.tid};
        if (mon_armed) begin
            chk("pkt_sent_timing", 64'(pkt_sent_o), 64'(exp_sent));
            if (rst_n_i && stall_pend) chk("stall_hold", 64'(cur), 64'(hold_vec));
            if (pkt_sent_o) sent_cnt++;
            if (size_err_o) err_cnt++;
        end
        if (rst_n_i && data_rd_o) begin
            rd_cnt++;
            if (src_q.size() > 0) void'(src_q.pop_front());
        end
        if (rst_n_i && pkt_if.tvalid && pkt_if.tready) begin
            beat_cnt++;
            last_keep_seen = pkt_if.tkeep;
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_beat actual=%0h required=no_beat", pkt_if.tdata);
            end else begin
                e = exp_q.pop_front();
                chk("beat", 64'({pkt_if.tdata, pkt_if.tkeep, pkt_if.tstrb, pkt_if.tlast,
                                 pkt_if.tuser, pkt_if.tdest, pkt_if.tid}),
                            64'({e.data, e.keep, e.keep, e.last, e.user, e.dest, e.id}));
            end
        end
        exp_sent   = rst_n_i && pkt_if.tvalid && pkt_if.tready && pkt_if.tlast;
        stall_pend = rst_n_i && pkt_if.tvalid && !pkt_if.tready;
        hold_vec   = cur;
        mon_armed  = 1'b1;
    end

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        logic seen;
        int   nz, nzero, nwords, sz;

        tbl[0] = '{10, 0, 3, 4'b0011, 0};
        tbl[1] = '{ 4, 0, 1, 4'b1111, 0};
        tbl[2] = '{12, 1, 3, 4'b1111, 0};
        tbl[3] = '{ 1, 2, 1, 4'b0001, 0};
        tbl[4] = '{ 7, 2, 2, 4'b0111, 0};
        tbl[5] = '{ 0, 0, 0, 4'b0000, 1};
        tbl[6] = '{13, 1, 4, 4'b0001, 0};

        rst_n_i = 1'b0; cmd_valid_i = 1'b0; cmd_size_i = '0;
        cmd_tuser_i = 1'b0; cmd_tdest_i = 1'b0; cmd_tid_i = 1'b0;
        refresh();
        tick(); tick(); tick();
        chk("reset_tvalid", 64'(pkt_if.tvalid), 64'd0);
        chk("reset_busy", 64'(busy_o), 64'd0);
        chk("reset_rd", 64'(data_rd_o), 64'd0);
        chk("reset_pulses", 64'({pkt_sent_o, size_err_o}), 64'd0);
        rst_n_i = 1'b1;
        tick();
        chk("reset_cmd_ready", 64'(cmd_ready_o), 64'd1);

        foreach (tbl[i]) begin
            ready_mode = tbl[i].mode;
            clear_counts();
            packet(tbl[i].size);
            wait_idle();
            chk("vec_beats", 64'(beat_cnt), 64'(tbl[i].exp_beats));
            chk("vec_pops", 64'(rd_cnt), 64'(tbl[i].exp_beats));
            chk("vec_sent", 64'(sent_cnt), 64'(tbl[i].exp_beats > 0 ? 1 : 0));
            chk("vec_size_err", 64'(err_cnt), 64'(tbl[i].exp_err));
            if (tbl[i].exp_beats > 0) chk("vec_last_keep", 64'(last_keep_seen), 64'(tbl[i].exp_last_keep));
            chk("vec_cmd_ready", 64'(cmd_ready_o), 64'd1);
        end

        // Single-word packet: command path frees up quickly.
        ready_mode = 0;
        clear_counts();
        issue(4, 1'b1, 1'b0, 1'b1);
        push_src(1);
        send_cmd(4, 1'b1, 1'b0, 1'b1);
        chk("one_word_ready_low", 64'(cmd_ready_o), 64'd0);
        seen = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            if (cmd_ready_o) begin seen = 1'b1; break; end
        end
        chk("one_word_ready_back", 64'(seen), 64'd1);
        wait_idle();
        chk("one_word_beats", 64'(beat_cnt), 64'd1);

        // Source runs dry after the first word.
        clear_counts();
        issue(8, 1'b0, 1'b1, 1'b0);
        push_src(1);
        send_cmd(8, 1'b0, 1'b1, 1'b0);
        tick(); tick();
        for (int k = 0; k < 4; k++) begin
            chk("gap_tvalid_low", 64'(pkt_if.tvalid), 64'd0);
            chk("gap_busy", 64'(busy_o), 64'd1);
            tick();
        end
        push_src(1);
        wait_idle();
        chk("gap_beats", 64'(beat_cnt), 64'd2);
        chk("gap_sent", 64'(sent_cnt), 64'd1);

        // Reset in the middle of a 4-word packet.
        clear_counts();
        issue(16, 1'b1, 1'b1, 1'b0);
        push_src(4);
        send_cmd(16, 1'b1, 1'b1, 1'b0);
        tick(); tick();
        rst_n_i = 1'b0;
        refresh();
        tick();
        chk("midrst_tvalid", 64'(pkt_if.tvalid), 64'd0);
        chk("midrst_cmd_ready", 64'(cmd_ready_o), 64'd1);
        chk("midrst_busy", 64'(busy_o), 64'd0);
        chk("midrst_beats", 64'(beat_cnt), 64'd1);
        exp_q.delete(); src_q.delete(); pend_q.delete();
        rst_n_i = 1'b1;
        refresh();
        tick();
        clear_counts();
        packet(4);
        wait_idle();
        chk("postrst_beats", 64'(beat_cnt), 64'd1);
        chk("postrst_sent", 64'(sent_cnt), 64'd1);

        // Randomized back-to-back traffic with source gaps and random backpressure.
        ready_mode = 2;
        gate_rand  = 1'b1;
        clear_counts();
        nz = 0; nzero = 0; nwords = 0;
        for (int p = 0; p < 40; p++) begin
            sz = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : int'($urandom_range(1, 40));
            if (sz == 0) nzero++; else nz++;
            nwords += (sz + 3) / 4;
            packet(sz);
        end
        wait_idle();
        chk("rand_sent", 64'(sent_cnt), 64'(nz));
        chk("rand_size_err", 64'(err_cnt), 64'(nzero));
        chk("rand_pops", 64'(rd_cnt), 64'(nwords));
        chk("rand_beats", 64'(beat_cnt), 64'(nwords));
        chk("rand_scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
